// File: rtl/ucsbece154b_mem_arbiter.sv
// ucsbece154b_mem_arbiter
// Shares one single-ported, variable-latency memory between the fetch port
// and the data port. One access is in flight at a time. Data wins ties
// unless fetch has lost STARVE_LIMIT grants in a row. Completion is a
// one-cycle valid pulse to the winner, and every output is a flop.
module ucsbece154b_mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_valid_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              dm_valid_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ready_i,
   output logic              busy_o
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUSY_IF = 2'd1,
      S_BUSY_DM = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic              if_valid_q, if_valid_d;
   logic              dm_valid_q, dm_valid_d;
   logic              mem_req_q, mem_req_d;
   logic              busy_q, busy_d;
   logic              dm_wins;

   // Arbitration, access tracking and registered-output next values.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d      = state_q;
      addr_d       = addr_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      if_rdata_d   = if_rdata_q;
      dm_rdata_d   = dm_rdata_q;
      starve_cnt_d = starve_cnt_q;
      if_valid_d   = 1'b0;
      dm_valid_d   = 1'b0;
      // Fetch is forced to win once it has been passed over STARVE_LIMIT times.
      dm_wins      = dm_req_i && !(if_req_i && (starve_cnt_q == CNT_MAX));

      case (state_q)
         S_IDLE: begin
            if (dm_wins) begin
               state_d = S_BUSY_DM;
               addr_d  = dm_addr_i;
               we_d    = dm_we_i;
               wdata_d = dm_wdata_i;
               if (if_req_i) begin
                  starve_cnt_d = (starve_cnt_q == CNT_MAX) ? CNT_MAX : starve_cnt_q + CNT_ONE;
               end else begin
                  starve_cnt_d = '0;
               end
            end else if (if_req_i) begin
               state_d      = S_BUSY_IF;
               addr_d       = if_addr_i;
               we_d         = 1'b0;
               starve_cnt_d = '0;
            end
         end
         S_BUSY_IF: begin
            if (mem_ready_i) begin
               if_rdata_d = mem_rdata_i;
               if_valid_d = 1'b1;
               state_d    = S_DONE;
            end
         end
         S_BUSY_DM: begin
            if (mem_ready_i) begin
               // Stores complete without touching the load data register.
               if (!we_q) begin
                  dm_rdata_d = mem_rdata_i;
               end
               dm_valid_d = 1'b1;
               state_d    = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Decoded from the next state so the flopped copies line up with state_q.
      mem_req_d = (state_d == S_BUSY_IF) || (state_d == S_BUSY_DM);
      busy_d    = (state_d != S_IDLE);
   end

   // State and output registers; reset abandons any in-flight access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         if_rdata_q   <= '0;
         dm_rdata_q   <= '0;
         starve_cnt_q <= '0;
         if_valid_q   <= 1'b0;
         dm_valid_q   <= 1'b0;
         mem_req_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q      <= state_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         if_rdata_q   <= if_rdata_d;
         dm_rdata_q   <= dm_rdata_d;
         starve_cnt_q <= starve_cnt_d;
         if_valid_q   <= if_valid_d;
         dm_valid_q   <= dm_valid_d;
         mem_req_q    <= mem_req_d;
         busy_q       <= busy_d;
      end
   end

   assign if_rdata_o  = if_rdata_q;
   assign if_valid_o  = if_valid_q;
   assign dm_rdata_o  = dm_rdata_q;
   assign dm_valid_o  = dm_valid_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Self-checking bench for ucsbece154b_mem_arbiter. The bench plays both
// requesters and the memory, predicts each grant from the arbitration rules
// and keeps a word-level memory image to predict returned data.
module tb_ucsbece154b_mem_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LIM = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req_i;
   logic [AW-1:0] if_addr_i;
   logic [DW-1:0] if_rdata_o;
   logic          if_valid_o;
   logic          dm_req_i;
   logic          dm_we_i;
   logic [AW-1:0] dm_addr_i;
   logic [DW-1:0] dm_wdata_i;
   logic [DW-1:0] dm_rdata_o;
   logic          dm_valid_o;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata_i;
   logic          mem_ready_i;
   logic          busy_o;

   always #5 clk = ~clk;

   ucsbece154b_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
      .clk         (clk),
      .reset       (reset),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_rdata_o  (if_rdata_o),
      .if_valid_o  (if_valid_o),
      .dm_req_i    (dm_req_i),
      .dm_we_i     (dm_we_i),
      .dm_addr_i   (dm_addr_i),
      .dm_wdata_i  (dm_wdata_i),
      .dm_rdata_o  (dm_rdata_o),
      .dm_valid_o  (dm_valid_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ready_i (mem_ready_i),
      .busy_o      (busy_o)
   );

   int checks = 0;
   int errors = 0;

   // Reference state: consecutive fetch losses, last returned words, memory image.
   int            exp_starve;
   logic [DW-1:0] exp_if_rdata;
   logic [DW-1:0] exp_dm_rdata;
   logic [DW-1:0] mem_model [logic [AW-1:0]];
   int            order [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_mem_req"},  mem_req_o,   0);
      check({tag, "_mem_we"},   mem_we_o,    0);
      check({tag, "_if_valid"}, if_valid_o,  0);
      check({tag, "_dm_valid"}, dm_valid_o,  0);
      check({tag, "_busy"},     busy_o,      0);
      check({tag, "_mem_addr"}, mem_addr_o,  0);
      check({tag, "_mem_wdata"},mem_wdata_o, 0);
      check({tag, "_if_rdata"}, if_rdata_o,  0);
      check({tag, "_dm_rdata"}, dm_rdata_o,  0);
   endtask

   // Called in an IDLE cycle with at least one request up. Predicts the winner,
   // acts as memory with 'lat' cycles of latency, checks the whole handshake,
   // then drops the winner's request in the following IDLE cycle.
   task automatic serve(input int lat, input bit perturb, output bit won_dm);
      bit            dm_win;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      logic [DW-1:0] rd;
      logic          we;
      dm_win = dm_req_i && !(if_req_i && exp_starve == LIM);
      if (dm_win) begin
         a  = dm_addr_i;
         we = dm_we_i;
         wd = dm_wdata_i;
         exp_starve = if_req_i ? ((exp_starve < LIM) ? exp_starve + 1 : LIM) : 0;
      end else begin
         a  = if_addr_i;
         we = 1'b0;
         wd = '0;
         exp_starve = 0;
      end
      rd = mem_model.exists(a) ? mem_model[a] : $urandom;
      step();
      for (int j = 1; j <= lat; j++) begin
         check("acc_mem_req",  mem_req_o,  1);
         check("acc_busy",     busy_o,     1);
         check("acc_mem_addr", mem_addr_o, a);
         check("acc_mem_we",   mem_we_o,   we);
         if (we) check("acc_mem_wdata", mem_wdata_o, wd);
         check("acc_if_valid", if_valid_o, 0);
         check("acc_dm_valid", dm_valid_o, 0);
         check("acc_if_rdata", if_rdata_o, exp_if_rdata);
         check("acc_dm_rdata", dm_rdata_o, exp_dm_rdata);
         if (perturb) begin
            if (dm_win) dm_addr_i = $urandom;
            else        if_addr_i = $urandom;
         end
         mem_ready_i = (j == lat);
         mem_rdata_i = (j == lat) ? rd : DW'($urandom);
         step();
      end
      if (dm_win) begin
         if (we) mem_model[a] = wd;
         else begin
            exp_dm_rdata = rd;
            mem_model[a] = rd;
         end
      end else begin
         exp_if_rdata = rd;
         mem_model[a] = rd;
      end
      // Completion cycle; memory may wiggle ready here without effect.
      mem_ready_i = 1'($urandom);
      mem_rdata_i = $urandom;
      check("done_if_valid", if_valid_o, !dm_win);
      check("done_dm_valid", dm_valid_o, dm_win);
      check("done_mem_req",  mem_req_o,  0);
      check("done_busy",     busy_o,     1);
      check("done_if_rdata", if_rdata_o, exp_if_rdata);
      check("done_dm_rdata", dm_rdata_o, exp_dm_rdata);
      step();
      mem_ready_i = 1'b0;
      check("idle_if_valid", if_valid_o, 0);
      check("idle_dm_valid", dm_valid_o, 0);
      check("idle_busy",     busy_o,     0);
      check("idle_mem_req",  mem_req_o,  0);
      check("idle_mem_addr", mem_addr_o, a);
      check("idle_mem_we",   mem_we_o,   we);
      if (dm_win) dm_req_i = 1'b0;
      else        if_req_i = 1'b0;
      won_dm = dm_win;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit w;
      int exp_order [6] = '{1, 1, 0, 1, 1, 0};

      reset       = 1'b1;
      if_req_i    = 1'b0;
      if_addr_i   = '0;
      dm_req_i    = 1'b0;
      dm_we_i     = 1'b0;
      dm_addr_i   = '0;
      dm_wdata_i  = '0;
      mem_rdata_i = '0;
      mem_ready_i = 1'b0;
      exp_starve   = 0;
      exp_if_rdata = '0;
      exp_dm_rdata = '0;
      repeat (2) step();
      check_zero("por");
      reset = 1'b0;
      step();
      check_zero("post_rst");

      // Fetch 0x40 with two cycles of latency.
      mem_model[32'h40] = 32'h0050_0093;
      if_req_i  = 1'b1;
      if_addr_i = 32'h40;
      serve(2, 1'b0, w);
      check("fetch_winner", w, 0);
      check("fetch_rdata", if_rdata_o, 32'h0050_0093);

      // Store then load back from 0x100.
      dm_req_i   = 1'b1;
      dm_we_i    = 1'b1;
      dm_addr_i  = 32'h100;
      dm_wdata_i = 32'hDEAD_BEEF;
      serve(1, 1'b0, w);
      check("store_dm_rdata_kept", dm_rdata_o, 32'h0);
      dm_req_i  = 1'b1;
      dm_we_i   = 1'b0;
      dm_addr_i = 32'h100;
      serve(3, 1'b0, w);
      check("load_rdata", dm_rdata_o, 32'hDEAD_BEEF);

      // Reset asserted mid-cycle while a store waits on memory.
      dm_req_i   = 1'b1;
      dm_we_i    = 1'b1;
      dm_addr_i  = 32'h200;
      dm_wdata_i = 32'h1234_5678;
      step();
      step();
      check("pre_rst_mem_req", mem_req_o, 1);
      mem_ready_i = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      check_zero("rst_mid");
      dm_req_i = 1'b0;
      dm_we_i  = 1'b0;
      step();
      reset = 1'b0;
      exp_starve   = 0;
      exp_if_rdata = '0;
      exp_dm_rdata = '0;
      step();
      check_zero("rst_after");
      if_req_i  = 1'b1;
      if_addr_i = 32'h40;
      serve(1, 1'b0, w);
      check("rst_refetch", if_rdata_o, 32'h0050_0093);

      // Simultaneous requests: data first, then fetch.
      if_req_i  = 1'b1;
      if_addr_i = 32'h80;
      dm_req_i  = 1'b1;
      dm_we_i   = 1'b0;
      dm_addr_i = 32'h100;
      serve(2, 1'b0, w);
      check("simul_first_dm", w, 1);
      serve(1, 1'b0, w);
      check("simul_second_dm", w, 0);

      // Starvation: fetch held, data reissued every time it completes.
      if_req_i  = 1'b1;
      if_addr_i = 32'h44;
      for (int r = 0; r < 6; r++) begin
         if (!dm_req_i) begin
            dm_req_i   = 1'b1;
            dm_we_i    = 1'($urandom);
            dm_addr_i  = {27'd0, 3'($urandom), 2'b00};
            dm_wdata_i = $urandom;
         end
         serve($urandom_range(1, 3), 1'b0, w);
         order.push_back(int'(w));
         if (!if_req_i && r < 5) begin
            if_req_i  = 1'b1;
            if_addr_i = {27'd0, 3'($urandom), 2'b00};
         end
      end
      for (int r = 0; r < 6; r++) check($sformatf("starve_order%0d", r), order[r], exp_order[r]);
      serve(1, 1'b0, w);
      check("starve_drain_dm", w, 1);

      // Ten wait states on a fetch while its address input wanders.
      if_req_i  = 1'b1;
      if_addr_i = 32'h48;
      serve(11, 1'b1, w);
      check("wait_winner", w, 0);

      // Randomized traffic.
      for (int it = 0; it < 40; it++) begin
         if (!if_req_i && ($urandom % 2 == 0)) begin
            if_req_i  = 1'b1;
            if_addr_i = {27'd0, 3'($urandom), 2'b00};
         end
         if (!dm_req_i && ($urandom % 3 != 0)) begin
            dm_req_i   = 1'b1;
            dm_we_i    = 1'($urandom);
            dm_addr_i  = {27'd0, 3'($urandom), 2'b00};
            dm_wdata_i = $urandom;
         end
         if (!if_req_i && !dm_req_i) begin
            mem_ready_i = 1'($urandom);
            step();
            mem_ready_i = 1'b0;
            check("rand_idle_busy",    busy_o,     0);
            check("rand_idle_mem_req", mem_req_o,  0);
            check("rand_idle_valid",   if_valid_o | dm_valid_o, 0);
         end else begin
            serve($urandom_range(1, 4), 1'b0, w);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
